// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BURST)
//   STAT_W      : width of each per-requester word counter (stats build)
//   MAX_REQ     : largest requester count the helpers support
//   onehot2idx  : binary index of the set bit of a one-hot vector
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 8;

  // OR-reduction of the set positions; exact for one-hot input, 0 for all-zero.
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches i_valid upward from i_start, wrapping from N-1 to 0, and returns
// the first set position.
//   i_valid [N-1:0]  : candidate vector
//   i_start [IW-1:0] : highest-priority position (must be < N)
//   o_idx   [IW-1:0] : index of the chosen candidate (0 when none)
//   o_found          : at least one candidate was set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Walk from the furthest offset down to offset 0 so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[(int'(i_start) + i) % N]) begin
        o_found = 1'b1;
        o_idx   = IW'((int'(i_start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one FIFO write port
// among NUM_REQ requesters, all in the FIFO write-clock domain.
// Ports:
//   clk_i          : FIFO write clock
//   rst_i          : synchronous active-low reset
//   req_valid_i    : per-requester word valid
//   req_data_i     : per-requester data, requester k at [k*WIDTH +: WIDTH]
//   req_last_i     : per-requester end-of-packet marker
//   req_ready_o    : per-requester accept (transfer = valid & ready)
//   grant_o        : one-hot current owner, zero when idle
//   fifo_wdata_o   : FIFO write data (zero outside a burst)
//   fifo_wenable_o : FIFO write enable
//   fifo_full_i    : FIFO full flag
//   busy_o         : high while a burst is granted
// Optional build macro FIFO_ARB_STATS_EN adds:
//   word_cnt_o     : NUM_REQ saturating 16-bit transfer counters
//   stats_clr_i    : synchronous clear of all counters (wins over increment)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [WIDTH-1:0]           fifo_wdata_o,
  output logic                       fifo_wenable_o,
  input  logic                       fifo_full_i,
  output logic                       busy_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  word_cnt_o,
  input  logic                       stats_clr_i
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_cnt_nxt;

  logic [MAX_REQ-1:0] w_grant_ext;
  logic [IDX_W-1:0]   w_gidx;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_in_burst;
  logic               w_xfer;
  logic               w_end;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .i_valid (req_valid_i),
    .i_start (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_grant_ext = MAX_REQ'(r_grant);
  assign w_gidx      = IDX_W'(onehot2idx(w_grant_ext));
  assign w_in_burst  = (r_state == ARB_BURST);
  assign w_xfer      = w_in_burst & req_valid_i[w_gidx] & ~fifo_full_i;
  // The word count check uses the pre-increment value: the MAX_BURST-th
  // transfer happens while the counter still reads MAX_BURST-1.
  assign w_end       = w_xfer & (req_last_i[w_gidx] | (r_burst_cnt == CNT_LAST));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ARB_BURST;
          w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      ARB_BURST: begin
        if (w_end) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = (w_gidx == IDX_TOP) ? '0 : w_gidx + IDX_W'(1);
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          w_cnt_nxt   = r_burst_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Output logic: the write port is a combinational pass-through of the owner
  always_comb begin
    req_ready_o    = '0;
    fifo_wdata_o   = '0;
    fifo_wenable_o = 1'b0;
    if (w_in_burst) begin
      fifo_wdata_o        = req_data_i[w_gidx*WIDTH +: WIDTH];
      fifo_wenable_o      = req_valid_i[w_gidx] & ~fifo_full_i;
      req_ready_o[w_gidx] = ~fifo_full_i;
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = w_in_burst;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_word_cnt [NUM_REQ];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rst_i || stats_clr_i) begin
        r_word_cnt[k] <= '0;
      end else if (w_xfer && (w_gidx == IDX_W'(k)) && (r_word_cnt[k] != '1)) begin
        r_word_cnt[k] <= r_word_cnt[k] + STAT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_word_cnt
    assign word_cnt_o[k*STAT_W +: STAT_W] = r_word_cnt[k];
  end
`endif

endmodule
